// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: steps the PE mesh through shift A, shift B and
// multiply-accumulate phases. Each command waits on the AND-reduced PE
// ready handshake, and a stuck handshake ends in a sticky error state.
module pe_array_sequencer #(
    parameter int NUM_IMAGES = 2,
    parameter int IDX_W      = 1,
    parameter int STEP_W     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [IDX_W-1:0]  slot_a,
    input  logic [IDX_W-1:0]  slot_b,
    input  logic [1:0]        dir_a,
    input  logic [1:0]        dir_b,
    input  logic              pe_ready,
    output logic              shift_up,
    output logic              shift_down,
    output logic              shift_left,
    output logic              shift_right,
    output logic [IDX_W-1:0]  image_shifting,
    output logic              start_multiply,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [STEP_W-1:0] step_count
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SHIFT_A = 4'd1;
    localparam logic [3:0] ST_WAIT_A  = 4'd2;
    localparam logic [3:0] ST_SHIFT_B = 4'd3;
    localparam logic [3:0] ST_WAIT_B  = 4'd4;
    localparam logic [3:0] ST_MULT    = 4'd5;
    localparam logic [3:0] ST_WAIT_M  = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

    // The wait counter never needs to count past TIMEOUT-1: that is the
    // last cycle in which a ready can still be accepted.
    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam int                SLOT_W     = IDX_W + 1;
    localparam logic [SLOT_W-1:0] SLOT_LIMIT = SLOT_W'(NUM_IMAGES);

    logic [3:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [STEP_W-1:0] num_steps_q;
    logic [IDX_W-1:0]  slot_a_q;
    logic [IDX_W-1:0]  slot_b_q;
    logic [1:0]        dir_a_q;
    logic [1:0]        dir_b_q;

    logic              slot_bad;
    logic              ready_ok;
    logic              wait_expired;
    logic [STEP_W-1:0] next_step;
    logic              shift_en;
    logic [1:0]        shift_dir;

    // The first cycle of each wait (count 0) is blanking, since PEs only
    // drop ready one cycle after receiving a command.
    assign slot_bad     = ({1'b0, slot_a} >= SLOT_LIMIT) || ({1'b0, slot_b} >= SLOT_LIMIT);
    assign ready_ok     = (wait_cnt != '0) && pe_ready;
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign next_step    = step_count + STEP_W'(1);

    // State, wait counter, step counter and latched run configuration.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            step_count  <= '0;
            num_steps_q <= '0;
            slot_a_q    <= '0;
            slot_b_q    <= '0;
            dir_a_q     <= '0;
            dir_b_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_steps_q <= num_steps;
                        slot_a_q    <= slot_a;
                        slot_b_q    <= slot_b;
                        dir_a_q     <= dir_a;
                        dir_b_q     <= dir_b;
                        step_count  <= '0;
                        if (slot_bad)
                            state <= ST_ERROR;
                        else if (num_steps == '0)
                            state <= ST_DONE;
                        else
                            state <= ST_SHIFT_A;
                    end
                end
                ST_SHIFT_A: begin
                    wait_cnt <= '0;
                    state    <= abort ? ST_IDLE : ST_WAIT_A;
                end
                ST_WAIT_A: begin
                    if (abort)
                        state <= ST_IDLE;
                    else if (ready_ok)
                        state <= ST_SHIFT_B;
                    else if (wait_expired)
                        state <= ST_ERROR;
                    else
                        wait_cnt <= wait_cnt + CNT_W'(1);
                end
                ST_SHIFT_B: begin
                    wait_cnt <= '0;
                    state    <= abort ? ST_IDLE : ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    if (abort)
                        state <= ST_IDLE;
                    else if (ready_ok)
                        state <= ST_MULT;
                    else if (wait_expired)
                        state <= ST_ERROR;
                    else
                        wait_cnt <= wait_cnt + CNT_W'(1);
                end
                ST_MULT: begin
                    wait_cnt <= '0;
                    state    <= abort ? ST_IDLE : ST_WAIT_M;
                end
                ST_WAIT_M: begin
                    if (abort)
                        state <= ST_IDLE;
                    else if (ready_ok) begin
                        step_count <= next_step;
                        state      <= (next_step == num_steps_q) ? ST_DONE : ST_SHIFT_A;
                    end else if (wait_expired)
                        state <= ST_ERROR;
                    else
                        wait_cnt <= wait_cnt + CNT_W'(1);
                end
                ST_DONE:  state <= ST_IDLE;
                ST_ERROR: state <= ST_ERROR;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Moore output decode from the registered state and latched config.
    always_comb begin
        shift_en       = 1'b0;
        shift_dir      = 2'd0;
        image_shifting = '0;
        start_multiply = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (state)
            ST_SHIFT_A: begin
                busy           = 1'b1;
                shift_en       = 1'b1;
                shift_dir      = dir_a_q;
                image_shifting = slot_a_q;
            end
            ST_SHIFT_B: begin
                busy           = 1'b1;
                shift_en       = 1'b1;
                shift_dir      = dir_b_q;
                image_shifting = slot_b_q;
            end
            ST_MULT: begin
                busy           = 1'b1;
                start_multiply = 1'b1;
            end
            ST_WAIT_A, ST_WAIT_B, ST_WAIT_M: busy = 1'b1;
            ST_DONE:  done  = 1'b1;
            ST_ERROR: error = 1'b1;
            default: ;
        endcase
        shift_up    = shift_en && (shift_dir == 2'd0);
        shift_down  = shift_en && (shift_dir == 2'd1);
        shift_left  = shift_en && (shift_dir == 2'd2);
        shift_right = shift_en && (shift_dir == 2'd3);
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer: directed vector table plus hand-written sequences
// for stalls, timeout, abort, start-while-busy and mid-run reset.
module tb_pe_array_sequencer;

    localparam int NUM_IMAGES = 2;
    localparam int IDX_W      = 2;
    localparam int STEP_W     = 8;
    localparam int TIMEOUT    = 64;

    typedef struct packed {
        logic       up;
        logic       down;
        logic       left;
        logic       right;
        logic [1:0] img;
        logic       mult;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] step;
    } outs_t;

    typedef struct {
        string      name;
        int         n;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] da;
        logic [1:0] db;
        int         done_cyc;
        logic       err;
        int         steps;
    } vec_t;

    logic              CLK = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [STEP_W-1:0] num_steps;
    logic [IDX_W-1:0]  slot_a;
    logic [IDX_W-1:0]  slot_b;
    logic [1:0]        dir_a;
    logic [1:0]        dir_b;
    logic              pe_ready;
    logic              shift_up;
    logic              shift_down;
    logic              shift_left;
    logic              shift_right;
    logic [IDX_W-1:0]  image_shifting;
    logic              start_multiply;
    logic              busy;
    logic              done;
    logic              error;
    logic [STEP_W-1:0] step_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    vec_t vecs[6];

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    pe_array_sequencer #(
        .NUM_IMAGES(NUM_IMAGES),
        .IDX_W(IDX_W),
        .STEP_W(STEP_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .start(start),
        .abort(abort),
        .num_steps(num_steps),
        .slot_a(slot_a),
        .slot_b(slot_b),
        .dir_a(dir_a),
        .dir_b(dir_b),
        .pe_ready(pe_ready),
        .shift_up(shift_up),
        .shift_down(shift_down),
        .shift_left(shift_left),
        .shift_right(shift_right),
        .image_shifting(image_shifting),
        .start_multiply(start_multiply),
        .busy(busy),
        .done(done),
        .error(error),
        .step_count(step_count)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic outs_t grab();
        outs_t a;
        a.up    = shift_up;
        a.down  = shift_down;
        a.left  = shift_left;
        a.right = shift_right;
        a.img   = image_shifting;
        a.mult  = start_multiply;
        a.busy  = busy;
        a.done  = done;
        a.err   = error;
        a.step  = step_count;
        return a;
    endfunction

    function automatic outs_t put_shift(input outs_t o, input logic [1:0] d, input logic [1:0] s);
        outs_t r;
        r       = o;
        r.up    = (d == 2'd0);
        r.down  = (d == 2'd1);
        r.left  = (d == 2'd2);
        r.right = (d == 2'd3);
        r.img   = s;
        return r;
    endfunction

    // Reference timeline of a run with ready always high: 9 cycles per step,
    // shift A / shift B / multiply at offsets 0 / 3 / 6, done right after.
    function automatic outs_t model(input int n, input int c, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] da,
                                    input logic [1:0] db, input logic bad_cfg);
        outs_t o;
        int    p;
        o = '0;
        if (c < 1) return o;
        if (bad_cfg) begin
            o.err = 1'b1;
            return o;
        end
        if (c <= 9 * n) begin
            p      = (c - 1) % 9;
            o.busy = 1'b1;
            o.step = 8'((c - 1) / 9);
            if (p == 0) o = put_shift(o, da, sa);
            if (p == 3) o = put_shift(o, db, sb);
            if (p == 6) o.mult = 1'b1;
        end else begin
            o.done = (c == 9 * n + 1);
            o.step = 8'(n);
        end
        return o;
    endfunction

    task automatic check_output(input string name, input outs_t exp);
        outs_t act;
        act = grab();
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        pe_ready = 1'b1;
        tick();
        tick();
        check_output("reset_state", '0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Presents a config with a one-cycle start; returns in cycle 1.
    task automatic apply_stimulus(input int n, input logic [1:0] sa, input logic [1:0] sb,
                                  input logic [1:0] da, input logic [1:0] db);
        num_steps = 8'(n);
        slot_a    = sa;
        slot_b    = sb;
        dir_a     = da;
        dir_b     = db;
        start     = 1'b1;
        cyc       = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        outs_t e;
        int    first_done;
        int    len;

        reset = 1'b1; start = 1'b0; abort = 1'b0; pe_ready = 1'b1;
        num_steps = '0; slot_a = '0; slot_b = '0; dir_a = '0; dir_b = '0;

        vecs[0] = '{"nominal_3step",   3, 2'd0, 2'd1, 2'd0, 2'd2, 28, 1'b0, 3};
        vecs[1] = '{"same_slot",       1, 2'd1, 2'd1, 2'd1, 2'd3, 10, 1'b0, 1};
        vecs[2] = '{"right_then_down", 2, 2'd0, 2'd0, 2'd3, 2'd1, 19, 1'b0, 2};
        vecs[3] = '{"zero_steps",      0, 2'd0, 2'd1, 2'd0, 2'd0,  1, 1'b0, 0};
        vecs[4] = '{"bad_slot_b",      3, 2'd0, 2'd2, 2'd0, 2'd2, -1, 1'b1, 0};
        vecs[5] = '{"bad_slot_a",      1, 2'd3, 2'd0, 2'd2, 2'd0, -1, 1'b1, 0};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            apply_stimulus(vecs[i].n, vecs[i].sa, vecs[i].sb, vecs[i].da, vecs[i].db);
            first_done = -1;
            len = vecs[i].err ? 6 : 9 * vecs[i].n + 4;
            while (cyc <= len) begin
                if (done === 1'b1 && first_done < 0) first_done = cyc;
                check_output(vecs[i].name, model(vecs[i].n, cyc, vecs[i].sa, vecs[i].sb,
                                                 vecs[i].da, vecs[i].db, vecs[i].err));
                tick();
            end
            check_int({vecs[i].name, "_done_cycle"}, first_done, vecs[i].done_cyc);
            check_int({vecs[i].name, "_error"}, int'(error), int'(vecs[i].err));
            check_int({vecs[i].name, "_steps"}, int'(step_count), vecs[i].steps);
        end

        // Ready held low for the 10 cycles it would be sampled after the
        // first multiply; the rest of the run slides by exactly 10 cycles.
        do_reset();
        apply_stimulus(2, 2'd0, 2'd1, 2'd0, 2'd2);
        while (cyc <= 32) begin
            pe_ready = (cyc >= 9 && cyc <= 18) ? 1'b0 : 1'b1;
            if (cyc <= 9)
                e = model(2, cyc, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0);
            else if (cyc <= 19) begin
                e = '0;
                e.busy = 1'b1;
            end else
                e = model(2, cyc - 10, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0);
            check_output("ready_stall", e);
            tick();
        end
        pe_ready = 1'b1;

        // Ready stuck low after the first shift: 64 wait cycles then error,
        // after which start and abort have no effect.
        do_reset();
        apply_stimulus(1, 2'd0, 2'd1, 2'd0, 2'd2);
        check_output("timeout_first_shift", model(1, 1, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0));
        pe_ready = 1'b0;
        tick();
        while (cyc <= 64) begin
            e = '0;
            e.busy = 1'b1;
            check_output("timeout_waiting", e);
            tick();
        end
        tick();
        while (cyc <= 80) begin
            if (cyc == 71) begin
                start = 1'b1; abort = 1'b1; pe_ready = 1'b1;
                num_steps = 8'd1; slot_a = 2'd0; slot_b = 2'd0;
            end
            if (cyc == 72) begin
                start = 1'b0; abort = 1'b0;
            end
            e = '0;
            e.err = 1'b1;
            check_output("timeout_error_sticky", e);
            tick();
        end

        // Abort during step 2 of a 5-step run: idle next cycle, no done.
        do_reset();
        apply_stimulus(5, 2'd0, 2'd1, 2'd0, 2'd2);
        while (cyc <= 20) begin
            if (cyc <= 12)
                e = model(5, cyc, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0);
            else begin
                e = '0;
                e.step = 8'd1;
            end
            check_output("abort", e);
            abort = (cyc == 12);
            tick();
        end
        abort = 1'b0;

        // A start with a different config arriving mid-run is ignored.
        do_reset();
        apply_stimulus(2, 2'd0, 2'd1, 2'd0, 2'd2);
        while (cyc <= 21) begin
            if (cyc == 5) begin
                start = 1'b1; num_steps = 8'd7;
                slot_a = 2'd1; dir_a = 2'd3; slot_b = 2'd0; dir_b = 2'd1;
            end else
                start = 1'b0;
            check_output("start_while_busy", model(2, cyc, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0));
            tick();
        end

        // Reset during a shift_right pulse, then a clean fresh run.
        do_reset();
        apply_stimulus(2, 2'd1, 2'd0, 2'd3, 2'd0);
        while (cyc <= 10) begin
            check_output("pre_reset_run", model(2, cyc, 2'd1, 2'd0, 2'd3, 2'd0, 1'b0));
            if (cyc == 10) reset = 1'b1;
            tick();
        end
        check_output("reset_mid_pulse", '0);
        reset = 1'b0;
        tick();
        check_output("idle_after_reset", '0);
        apply_stimulus(1, 2'd1, 2'd0, 2'd3, 2'd1);
        while (cyc <= 12) begin
            check_output("run_after_reset", model(1, cyc, 2'd1, 2'd0, 2'd3, 2'd1, 1'b0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
